// File: rtl/spi_cfg_regs.sv
// SPI-slave configuration register bank: oversampled mode-0 pins, 32-bit write frames, tuning/gain/enable registers.
// Optional read frames driving miso are enabled by defining SPI_READBACK_EN.
module spi_cfg_regs #(
   parameter int                PINC_W   = 24,
   parameter logic [PINC_W-1:0] PINC_RST = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              mosi,
   input  logic              csb,
   output logic              miso,
   output logic [PINC_W-1:0] phase_inc,
   output logic [3:0]        gain,
   output logic              rx_en,
   output logic              pwm_en,
   output logic              cfg_update,
   output logic              frame_err
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t            state_q;
   logic [2:0]        sckSync_q;
   logic [2:0]        csbSync_q;
   logic [1:0]        mosiSync_q;
   logic [31:0]       shift_q;
   logic [31:0]       shift_d;
   logic [5:0]        cnt_q;
   logic [PINC_W-1:0] phaseInc_q;
   logic [3:0]        gain_q;
   logic              rxEn_q;
   logic              pwmEn_q;
   logic              cfgUpdate_q;
   logic              frameErr_q;
   logic              sckRise;
   logic              csbRise;
   logic              csbFall;

   // Synchronizers reset low so a CSb held low across reset release never looks like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sckSync_q  <= '0;
         csbSync_q  <= '0;
         mosiSync_q <= '0;
      end else begin
         sckSync_q  <= {sckSync_q[1:0], sck};
         csbSync_q  <= {csbSync_q[1:0], csb};
         mosiSync_q <= {mosiSync_q[0], mosi};
      end
   end

   assign sckRise = sckSync_q[1] & ~sckSync_q[2];
   assign csbRise = csbSync_q[1] & ~csbSync_q[2];
   assign csbFall = ~csbSync_q[1] & csbSync_q[2];
   assign shift_d = {shift_q[30:0], mosiSync_q[1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         phaseInc_q  <= PINC_RST;
         gain_q      <= '0;
         rxEn_q      <= 1'b0;
         pwmEn_q     <= 1'b0;
         cfgUpdate_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         cfgUpdate_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (csbFall) begin
                  shift_q <= '0;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               // A last SCK edge coinciding with CSb rise is still shifted; COMMIT sees the final count.
               if (sckRise) begin
                  shift_q <= shift_d;
                  if (cnt_q < 6'd33) cnt_q <= cnt_q + 6'd1;
               end
               if (csbRise) state_q <= COMMIT;
            end
            COMMIT: begin
               state_q <= IDLE;
               if (cnt_q != 6'd32) begin
                  frameErr_q <= 1'b1;
               end else begin
                  case (shift_q[31:24])
                     8'h00: begin
                        phaseInc_q  <= shift_q[PINC_W-1:0];
                        cfgUpdate_q <= 1'b1;
                     end
                     8'h01: begin
                        gain_q      <= shift_q[3:0];
                        cfgUpdate_q <= 1'b1;
                     end
                     8'h02: begin
                        rxEn_q      <= shift_q[0];
                        pwmEn_q     <= shift_q[1];
                        cfgUpdate_q <= 1'b1;
                        if (shift_q[7]) frameErr_q <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SPI_READBACK_EN
   logic        sckFall;
   logic [23:0] rdData;
   logic [23:0] rdShift_q;
   logic        rdActive_q;
   logic        miso_q;

   assign sckFall = ~sckSync_q[1] & sckSync_q[2];

   always_comb begin
      rdData = '0;
      case (shift_d[6:0])
         7'h00:   rdData[PINC_W-1:0] = phaseInc_q;
         7'h01:   rdData[3:0]        = gain_q;
         7'h02:   rdData[1:0]        = {pwmEn_q, rxEn_q};
         default: rdData = '0;
      endcase
   end

   // Load on the 8th address bit's rising edge; each following SCK fall presents the next bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdShift_q  <= '0;
         rdActive_q <= 1'b0;
         miso_q     <= 1'b0;
      end else if (state_q != SHIFT) begin
         rdActive_q <= 1'b0;
         miso_q     <= 1'b0;
      end else if (sckRise && cnt_q == 6'd7 && shift_d[7]) begin
         rdShift_q  <= rdData;
         rdActive_q <= 1'b1;
      end else if (sckFall && rdActive_q) begin
         miso_q    <= rdShift_q[23];
         rdShift_q <= {rdShift_q[22:0], 1'b0};
      end
   end

   assign miso = miso_q;
`else
   assign miso = 1'b0;
`endif

   assign phase_inc  = phaseInc_q;
   assign gain       = gain_q;
   assign rx_en      = rxEn_q;
   assign pwm_en     = pwmEn_q;
   assign cfg_update = cfgUpdate_q;
   assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Self-checking bench for spi_cfg_regs: table of SPI frames with expected register state, plus reset/readback sequences.
module tb_spi_cfg_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sck;
   logic        mosi;
   logic        csb;
   logic        miso;
   logic [23:0] phase_inc;
   logic [3:0]  gain;
   logic        rx_en;
   logic        pwm_en;
   logic        cfg_update;
   logic        frame_err;

   int          total = 0;
   int          bad = 0;
   int          pulses;
   int          pulseAt;
   logic [31:0] misoCap;

   typedef struct {
      logic [31:0] word;
      int          nbits;
      logic [23:0] pinc;
      logic [3:0]  gain;
      logic        rx;
      logic        pwm;
      logic        err;
      int          pulses;
   } vec_t;

   vec_t vecs[10];

   spi_cfg_regs #(.PINC_W(24), .PINC_RST(24'h000000)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .csb(csb), .miso(miso),
      .phase_inc(phase_inc), .gain(gain), .rx_en(rx_en), .pwm_en(pwm_en),
      .cfg_update(cfg_update), .frame_err(frame_err)
   );

   // 10 ns system clock; SPI phases below last 4 clk each
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Clock bits first..last of a frame; bits past 31 are sent as 0; miso captured before each rising SCK
   task automatic shiftBits(input logic [31:0] word, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         mosi = (i < 32) ? word[31 - i] : 1'b0;
         repeat (4) @(negedge clk);
         misoCap = {misoCap[30:0], miso};
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   // Raise CSb and watch 8 cycles for cfg_update pulses and their position
   task automatic watchCommit();
      csb = 1'b1;
      pulses  = 0;
      pulseAt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (cfg_update) begin
            pulses++;
            pulseAt = k;
         end
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [31:0] word, input int nbits);
      misoCap = '0;
      csb = 1'b0;
      repeat (4) @(negedge clk);
      shiftBits(word, 0, nbits - 1);
      repeat (4) @(negedge clk);
      watchCommit();
   endtask

   task automatic checkRegs(input string tag, input logic [23:0] pinc, input logic [3:0] g,
                            input logic rx, input logic pwm, input logic err);
      checkOutput({tag, ".phase_inc"}, {8'h0, phase_inc}, {8'h0, pinc});
      checkOutput({tag, ".gain"}, {28'h0, gain}, {28'h0, g});
      checkOutput({tag, ".rx_en"}, {31'h0, rx_en}, {31'h0, rx});
      checkOutput({tag, ".pwm_en"}, {31'h0, pwm_en}, {31'h0, pwm});
      checkOutput({tag, ".frame_err"}, {31'h0, frame_err}, {31'h0, err});
   endtask

   initial begin
      //                word          bits pinc       gain  rx    pwm   err   pulses
      vecs[0] = '{32'h00123456, 32, 24'h123456, 4'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[1] = '{32'h02000003, 32, 24'h123456, 4'h0, 1'b1, 1'b1, 1'b0, 1};
      vecs[2] = '{32'h0100000A, 32, 24'h123456, 4'hA, 1'b1, 1'b1, 1'b0, 1};
      vecs[3] = '{32'h00111111, 31, 24'h123456, 4'hA, 1'b1, 1'b1, 1'b1, 0};
      vecs[4] = '{32'h00222222, 33, 24'h123456, 4'hA, 1'b1, 1'b1, 1'b1, 0};
      vecs[5] = '{32'h02000080, 32, 24'h123456, 4'hA, 1'b0, 1'b0, 1'b0, 1};
      vecs[6] = '{32'h05FFFFFF, 32, 24'h123456, 4'hA, 1'b0, 1'b0, 1'b0, 0};
      vecs[7] = '{32'h80000000, 32, 24'h123456, 4'hA, 1'b0, 1'b0, 1'b0, 0};
      vecs[8] = '{32'h01FFFFF5, 32, 24'h123456, 4'h5, 1'b0, 1'b0, 1'b0, 1};
      vecs[9] = '{32'h03FFFFFF, 32, 24'h123456, 4'h5, 1'b0, 1'b0, 1'b0, 0};

      rst_n = 1'b0;
      csb   = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      misoCap = '0;
      repeat (3) @(negedge clk);
      checkRegs("reset", 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset.cfg_update", {31'h0, cfg_update}, 32'h0);
      checkOutput("reset.miso", {31'h0, miso}, 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].word, vecs[v].nbits);
         checkOutput($sformatf("vec%0d.pulses", v), pulses, vecs[v].pulses);
         if (vecs[v].pulses > 0)
            checkOutput($sformatf("vec%0d.pulse_latency", v), pulseAt, 4);
         checkRegs($sformatf("vec%0d", v), vecs[v].pinc, vecs[v].gain, vecs[v].rx, vecs[v].pwm, vecs[v].err);
      end

      // Reset in the middle of a write; the remainder of that frame must be ignored
      csb = 1'b0;
      repeat (4) @(negedge clk);
      shiftBits(32'h00ABCDEF, 0, 15);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      shiftBits(32'h00ABCDEF, 16, 31);
      repeat (4) @(negedge clk);
      watchCommit();
      checkOutput("midreset.pulses", pulses, 0);
      checkRegs("midreset", 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);

      // Next frame after the aborted one must work normally
      applyStimulus(32'h00654321, 32);
      checkOutput("postreset.pulses", pulses, 1);
      checkRegs("postreset", 24'h654321, 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef SPI_READBACK_EN
      applyStimulus(32'h00ABCDEF, 32);
      checkOutput("rbwrite.pulses", pulses, 1);
      applyStimulus(32'h80000000, 32);
      checkOutput("readback.pulses", pulses, 0);
      checkOutput("readback.miso_data", {8'h0, misoCap[23:0]}, 32'h00ABCDEF);
      checkOutput("readback.miso_addr_phase", {24'h0, misoCap[31:24]}, 32'h0);
      checkRegs("readback", 24'hABCDEF, 4'h0, 1'b0, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
